// File: rtl/injector_vnvc_request_queue.sv
// Per-(VN,VC) flit queues with downstream credit tracking for the injector arbiter.
// Requests come from registered state; a granted queue is popped and its flit registered out.
module injector_vnvc_request_queue #(
  parameter int NUM_VC      = 1,
  parameter int NUM_VN      = 3,
  parameter int FLIT_SIZE   = 64,
  parameter int FIFO_DEPTH  = 4,
  parameter int MAX_CREDITS = 4,
  localparam int NUM_VN_X_VC  = NUM_VC * NUM_VN,
  localparam int BITS_VN_X_VC = (NUM_VN_X_VC > 1) ? $clog2(NUM_VN_X_VC) : 1
) (
  input  logic                    clk,
  input  logic                    rst_p,
  input  logic [FLIT_SIZE-1:0]    flit_in,
  input  logic                    flit_in_valid,
  input  logic [BITS_VN_X_VC-1:0] flit_in_qid,
  output logic [NUM_VN_X_VC-1:0]  in_full,
  output logic [NUM_VN_X_VC-1:0]  request_vector,
  input  logic [NUM_VN_X_VC-1:0]  grant_vector,
  output logic [NUM_VN_X_VC-1:0]  grants_out,
  output logic [FLIT_SIZE-1:0]    flit_out,
  output logic                    flit_out_valid,
  output logic [BITS_VN_X_VC-1:0] flit_out_qid,
  input  logic [NUM_VN_X_VC-1:0]  credit_in,
  output logic                    credit_err
);

  localparam int NQ  = NUM_VN_X_VC;
  localparam int QW  = BITS_VN_X_VC;
  localparam int PW  = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int CRW = (MAX_CREDITS > 1) ? $clog2(MAX_CREDITS + 1) : 1;

  logic [FLIT_SIZE-1:0] mem_q [NQ][FIFO_DEPTH];

  logic [PW-1:0]  wr_ptr_q [NQ];
  logic [PW-1:0]  wr_ptr_d [NQ];
  logic [PW-1:0]  rd_ptr_q [NQ];
  logic [PW-1:0]  rd_ptr_d [NQ];
  logic [CW-1:0]  count_q  [NQ];
  logic [CW-1:0]  count_d  [NQ];
  logic [CRW-1:0] cr_q     [NQ];
  logic [CRW-1:0] cr_d     [NQ];

  logic                 credit_err_q, credit_err_d;
  logic                 flit_out_valid_q, flit_out_valid_d;
  logic [FLIT_SIZE-1:0] flit_out_q, flit_out_d;
  logic [QW-1:0]        flit_out_qid_q, flit_out_qid_d;
  logic [NQ-1:0]        grants_out_q, grants_out_d;

  logic          push_en;
  logic          serve_any;
  logic [QW-1:0] serve_idx;

  always_comb begin
    for (int i = 0; i < NQ; i++) begin
      request_vector[i] = (count_q[i] != '0) && (cr_q[i] != '0);
      in_full[i]        = (count_q[i] == CW'(FIFO_DEPTH));
    end
  end

  assign push_en = flit_in_valid && (int'(flit_in_qid) < NQ) && !in_full[flit_in_qid];

  // Scan from the top so the last hit is the lowest requesting granted index.
  always_comb begin
    serve_any = 1'b0;
    serve_idx = '0;
    for (int i = NQ - 1; i >= 0; i--) begin
      if (grant_vector[i] && request_vector[i]) begin
        serve_any = 1'b1;
        serve_idx = QW'(i);
      end
    end
  end

  always_comb begin
    credit_err_d     = credit_err_q;
    flit_out_valid_d = serve_any;
    flit_out_d       = flit_out_q;
    flit_out_qid_d   = flit_out_qid_q;
    grants_out_d     = '0;
    for (int i = 0; i < NQ; i++) begin
      logic push_i;
      logic pop_i;
      push_i      = push_en && (flit_in_qid == QW'(i));
      pop_i       = serve_any && (serve_idx == QW'(i));
      wr_ptr_d[i] = push_i ? wr_ptr_q[i] + PW'(1) : wr_ptr_q[i];
      rd_ptr_d[i] = pop_i  ? rd_ptr_q[i] + PW'(1) : rd_ptr_q[i];
      count_d[i]  = count_q[i];
      if (push_i && !pop_i) count_d[i] = count_q[i] + CW'(1);
      if (!push_i && pop_i) count_d[i] = count_q[i] - CW'(1);
      cr_d[i] = cr_q[i];
      if (pop_i && !credit_in[i]) begin
        cr_d[i] = cr_q[i] - CRW'(1);
      end else if (!pop_i && credit_in[i]) begin
        if (cr_q[i] == CRW'(MAX_CREDITS)) credit_err_d = 1'b1;
        else cr_d[i] = cr_q[i] + CRW'(1);
      end
    end
    if (serve_any) begin
      flit_out_d     = mem_q[serve_idx][rd_ptr_q[serve_idx]];
      flit_out_qid_d = serve_idx;
      grants_out_d   = NQ'(1) << serve_idx;
    end
  end

  // Storage has no reset; emptiness is carried entirely by the counters.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[flit_in_qid][wr_ptr_q[flit_in_qid]] <= flit_in;
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      for (int i = 0; i < NQ; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
        cr_q[i]     <= CRW'(MAX_CREDITS);
      end
      credit_err_q     <= 1'b0;
      flit_out_valid_q <= 1'b0;
      flit_out_q       <= '0;
      flit_out_qid_q   <= '0;
      grants_out_q     <= '0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      cr_q             <= cr_d;
      credit_err_q     <= credit_err_d;
      flit_out_valid_q <= flit_out_valid_d;
      flit_out_q       <= flit_out_d;
      flit_out_qid_q   <= flit_out_qid_d;
      grants_out_q     <= grants_out_d;
    end
  end

  assign credit_err     = credit_err_q;
  assign flit_out_valid = flit_out_valid_q;
  assign flit_out       = flit_out_q;
  assign flit_out_qid   = flit_out_qid_q;
  assign grants_out     = grants_out_q;

endmodule

// File: tb/tb_injector_vnvc_request_queue.sv
// Directed bench for injector_vnvc_request_queue: a cycle table of inputs and
// hand-computed outputs, plus hand sequences for reset and sticky credit error.
module tb_injector_vnvc_request_queue;

  logic        clk = 1'b0;
  logic        rst_p;
  logic [63:0] flit_in;
  logic        flit_in_valid;
  logic [1:0]  flit_in_qid;
  logic [2:0]  in_full;
  logic [2:0]  request_vector;
  logic [2:0]  grant_vector;
  logic [2:0]  grants_out;
  logic [63:0] flit_out;
  logic        flit_out_valid;
  logic [1:0]  flit_out_qid;
  logic [2:0]  credit_in;
  logic        credit_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        push;
    logic [1:0]  qid;
    logic [63:0] flit;
    logic [2:0]  grant;
    logic [2:0]  credit;
    logic        ev;
    logic [63:0] ef;
    logic [1:0]  eq;
    logic [2:0]  eg;
    logic [2:0]  er;
    logic [2:0]  efull;
    logic        eerr;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  injector_vnvc_request_queue dut (
    .clk            (clk),
    .rst_p          (rst_p),
    .flit_in        (flit_in),
    .flit_in_valid  (flit_in_valid),
    .flit_in_qid    (flit_in_qid),
    .in_full        (in_full),
    .request_vector (request_vector),
    .grant_vector   (grant_vector),
    .grants_out     (grants_out),
    .flit_out       (flit_out),
    .flit_out_valid (flit_out_valid),
    .flit_out_qid   (flit_out_qid),
    .credit_in      (credit_in),
    .credit_err     (credit_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic push, input logic [1:0] qid, input logic [63:0] flit,
                              input logic [2:0] grant, input logic [2:0] credit,
                              input logic ev, input logic [63:0] ef, input logic [1:0] eq,
                              input logic [2:0] eg, input logic [2:0] er,
                              input logic [2:0] efull, input logic eerr);
    vec_t v;
    v.push = push; v.qid = qid; v.flit = flit; v.grant = grant; v.credit = credit;
    v.ev = ev; v.ef = ef; v.eq = eq; v.eg = eg; v.er = er; v.efull = efull; v.eerr = eerr;
    tbl.push_back(v);
  endfunction

  task automatic drive(input logic push, input logic [1:0] qid, input logic [63:0] flit,
                       input logic [2:0] grant, input logic [2:0] credit);
    flit_in_valid = push;
    flit_in_qid   = qid;
    flit_in       = flit;
    grant_vector  = grant;
    credit_in     = credit;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " request_vector"}, 64'(request_vector), 64'h0);
    chk({tag, " in_full"},        64'(in_full),        64'h0);
    chk({tag, " grants_out"},     64'(grants_out),     64'h0);
    chk({tag, " flit_out"},       flit_out,            64'h0);
    chk({tag, " flit_out_valid"}, 64'(flit_out_valid), 64'h0);
    chk({tag, " flit_out_qid"},   64'(flit_out_qid),   64'h0);
    chk({tag, " credit_err"},     64'(credit_err),     64'h0);
  endtask

  initial begin
    // push qid 1 A,B with grant 010 held
    add(1, 1, 64'hA0, 3'b000, 3'b000, 0, 64'h0,  0, 3'b000, 3'b010, 3'b000, 0);
    add(1, 1, 64'hB0, 3'b010, 3'b000, 1, 64'hA0, 1, 3'b010, 3'b010, 3'b000, 0);
    add(0, 0, 64'h0,  3'b010, 3'b000, 1, 64'hB0, 1, 3'b010, 3'b000, 3'b000, 0);
    add(0, 0, 64'h0,  3'b010, 3'b000, 0, 64'h0,  0, 3'b000, 3'b000, 3'b000, 0);
    // fill qid 0, fifth push dropped, exactly four drain
    add(1, 0, 64'hD0, 3'b000, 3'b000, 0, 64'h0,  0, 3'b000, 3'b001, 3'b000, 0);
    add(1, 0, 64'hD1, 3'b000, 3'b000, 0, 64'h0,  0, 3'b000, 3'b001, 3'b000, 0);
    add(1, 0, 64'hD2, 3'b000, 3'b000, 0, 64'h0,  0, 3'b000, 3'b001, 3'b000, 0);
    add(1, 0, 64'hD3, 3'b000, 3'b000, 0, 64'h0,  0, 3'b000, 3'b001, 3'b001, 0);
    add(1, 0, 64'hD4, 3'b000, 3'b000, 0, 64'h0,  0, 3'b000, 3'b001, 3'b001, 0);
    add(0, 0, 64'h0,  3'b001, 3'b000, 1, 64'hD0, 0, 3'b001, 3'b001, 3'b000, 0);
    add(0, 0, 64'h0,  3'b001, 3'b000, 1, 64'hD1, 0, 3'b001, 3'b001, 3'b000, 0);
    add(0, 0, 64'h0,  3'b001, 3'b000, 1, 64'hD2, 0, 3'b001, 3'b001, 3'b000, 0);
    add(0, 0, 64'h0,  3'b001, 3'b000, 1, 64'hD3, 0, 3'b001, 3'b000, 3'b000, 0);
    add(0, 0, 64'h0,  3'b001, 3'b000, 0, 64'h0,  0, 3'b000, 3'b000, 3'b000, 0);
    // refill qid 0 with credits returning: pointers wrap
    add(1, 0, 64'hE0, 3'b000, 3'b001, 0, 64'h0,  0, 3'b000, 3'b001, 3'b000, 0);
    add(1, 0, 64'hE1, 3'b000, 3'b001, 0, 64'h0,  0, 3'b000, 3'b001, 3'b000, 0);
    add(1, 0, 64'hE2, 3'b000, 3'b001, 0, 64'h0,  0, 3'b000, 3'b001, 3'b000, 0);
    add(1, 0, 64'hE3, 3'b000, 3'b001, 0, 64'h0,  0, 3'b000, 3'b001, 3'b001, 0);
    add(0, 0, 64'h0,  3'b001, 3'b000, 1, 64'hE0, 0, 3'b001, 3'b001, 3'b000, 0);
    add(0, 0, 64'h0,  3'b001, 3'b000, 1, 64'hE1, 0, 3'b001, 3'b001, 3'b000, 0);
    add(0, 0, 64'h0,  3'b001, 3'b000, 1, 64'hE2, 0, 3'b001, 3'b001, 3'b000, 0);
    add(0, 0, 64'h0,  3'b001, 3'b000, 1, 64'hE3, 0, 3'b001, 3'b000, 3'b000, 0);
    // credit exhaustion on qid 2
    add(1, 2, 64'h60, 3'b100, 3'b000, 0, 64'h0,  0, 3'b000, 3'b100, 3'b000, 0);
    add(1, 2, 64'h61, 3'b100, 3'b000, 1, 64'h60, 2, 3'b100, 3'b100, 3'b000, 0);
    add(1, 2, 64'h62, 3'b100, 3'b000, 1, 64'h61, 2, 3'b100, 3'b100, 3'b000, 0);
    add(1, 2, 64'h63, 3'b100, 3'b000, 1, 64'h62, 2, 3'b100, 3'b100, 3'b000, 0);
    add(1, 2, 64'h64, 3'b100, 3'b000, 1, 64'h63, 2, 3'b100, 3'b000, 3'b000, 0);
    add(1, 2, 64'h65, 3'b100, 3'b000, 0, 64'h0,  0, 3'b000, 3'b000, 3'b000, 0);
    add(0, 0, 64'h0,  3'b100, 3'b100, 0, 64'h0,  0, 3'b000, 3'b100, 3'b000, 0);
    add(0, 0, 64'h0,  3'b100, 3'b000, 1, 64'h64, 2, 3'b100, 3'b000, 3'b000, 0);
    add(0, 0, 64'h0,  3'b100, 3'b000, 0, 64'h0,  0, 3'b000, 3'b000, 3'b000, 0);
    // multi-hot grant serves lowest; grant on empty queue ignored
    add(1, 0, 64'h70, 3'b000, 3'b101, 0, 64'h0,  0, 3'b000, 3'b101, 3'b000, 0);
    add(0, 0, 64'h0,  3'b111, 3'b000, 1, 64'h70, 0, 3'b001, 3'b100, 3'b000, 0);
    add(0, 0, 64'h0,  3'b010, 3'b000, 0, 64'h0,  0, 3'b000, 3'b100, 3'b000, 0);
    add(0, 0, 64'h0,  3'b100, 3'b000, 1, 64'h65, 2, 3'b100, 3'b000, 3'b000, 0);
    // qid 1 credits back to max, then one too many
    add(0, 0, 64'h0,  3'b000, 3'b010, 0, 64'h0,  0, 3'b000, 3'b000, 3'b000, 0);
    add(0, 0, 64'h0,  3'b000, 3'b010, 0, 64'h0,  0, 3'b000, 3'b000, 3'b000, 0);
    add(0, 0, 64'h0,  3'b000, 3'b010, 0, 64'h0,  0, 3'b000, 3'b000, 3'b000, 1);
    add(0, 0, 64'h0,  3'b000, 3'b000, 0, 64'h0,  0, 3'b000, 3'b000, 3'b000, 1);

    // clock/reset
    rst_p = 1'b1;
    drive(0, 0, 64'h0, 3'b000, 3'b000);
    repeat (3) @(posedge clk);
    #1 chk_all_zero("in_reset");
    @(negedge clk) rst_p = 1'b0;
    @(posedge clk);
    #1 chk_all_zero("idle");

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      drive(tbl[k].push, tbl[k].qid, tbl[k].flit, tbl[k].grant, tbl[k].credit);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d flit_out_valid", k), 64'(flit_out_valid), 64'(tbl[k].ev));
      chk($sformatf("v%0d grants_out", k),     64'(grants_out),     64'(tbl[k].eg));
      chk($sformatf("v%0d request_vector", k), 64'(request_vector), 64'(tbl[k].er));
      chk($sformatf("v%0d in_full", k),        64'(in_full),        64'(tbl[k].efull));
      chk($sformatf("v%0d credit_err", k),     64'(credit_err),     64'(tbl[k].eerr));
      if (tbl[k].ev) begin
        chk($sformatf("v%0d flit_out", k),     flit_out,            tbl[k].ef);
        chk($sformatf("v%0d flit_out_qid", k), 64'(flit_out_qid),   64'(tbl[k].eq));
      end
    end

    // reset in the middle of a drain on qid 1
    @(negedge clk) drive(1, 1, 64'h80, 3'b000, 3'b000);
    @(negedge clk) drive(1, 1, 64'h81, 3'b010, 3'b000);
    @(negedge clk) drive(1, 1, 64'h82, 3'b010, 3'b000);
    @(posedge clk);
    #1;
    chk("pre_reset flit_out_valid", 64'(flit_out_valid), 64'h1);
    chk("pre_reset flit_out",       flit_out,            64'h81);
    #2 rst_p = 1'b1;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    drive(0, 0, 64'h0, 3'b000, 3'b000);
    rst_p = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset request_vector", 64'(request_vector), 64'h0);
    chk("post_reset in_full",        64'(in_full),        64'h0);
    chk("post_reset flit_out_valid", 64'(flit_out_valid), 64'h0);
    @(negedge clk) drive(0, 0, 64'h0, 3'b010, 3'b000);
    @(posedge clk);
    #1;
    chk("post_reset grant_empty valid", 64'(flit_out_valid), 64'h0);
    chk("post_reset grant_empty grants", 64'(grants_out),    64'h0);

    // credit returned to qid 0 already at max after reset
    @(negedge clk) drive(0, 0, 64'h0, 3'b000, 3'b001);
    @(posedge clk);
    #1 chk("credit_err set", 64'(credit_err), 64'h1);
    @(negedge clk) drive(0, 0, 64'h0, 3'b000, 3'b000);
    repeat (2) @(posedge clk);
    #1 chk("credit_err sticky", 64'(credit_err), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
